// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: inter-stage pipeline register with a valid/ready handshake
// and a one-entry skid buffer. in_ready is derived only from registered
// occupancy, so back-pressure never forms a combinational path between stages.
module pipe_skid_stage #(
    parameter int WIDTH           = 32,
    parameter bit CLEAR_ON_BUBBLE = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_fire;
    logic             out_fire;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign occupancy = state_q;

    // State register: occupancy count, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= EMPTY;
        else      state_q <= state_d;
    end

    // Next-state logic; flush overrides every transfer in the same cycle.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (in_fire) state_d = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state_d = FULL;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                end
                FULL:    if (out_fire) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Outputs depend only on registered state; the bubble mask keeps stale
    // payload (and its control flags) from reaching downstream logic.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        if (CLEAR_ON_BUBBLE) out_data = main_q & {WIDTH{out_valid}};
        else                 out_data = main_q;
    end

    // Payload registers. A beat accepted during flush is never written, so
    // it cannot surface on out_data even with masking disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            case (state_q)
                EMPTY: if (in_fire) main_q <= in_data;
                ONE: begin
                    if (in_fire && out_fire)  main_q <= in_data;
                    if (in_fire && !out_fire) skid_q <= in_data;
                end
                FULL:  if (out_fire) main_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: a queue-based reference (at most two entries,
// head visible on the output) is compared on every falling edge, plus
// directed vectors with hand-computed literal expectations.
module tb_pipe_skid_stage;

    localparam int W = 107;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;

    // second instance: payload masking disabled, 32-bit
    logic          b_flush = 1'b0;
    logic          b_in_valid = 1'b0;
    logic          b_out_ready = 1'b0;
    logic [31:0]   b_in_data = '0;
    logic          b_in_ready;
    logic          b_out_valid;
    logic [31:0]   b_out_data;
    logic [1:0]    b_occupancy;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    logic [W-1:0] mq[$];

    always #5 clk = ~clk;

    pipe_skid_stage #(.WIDTH(W), .CLEAR_ON_BUBBLE(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_skid_stage #(.WIDTH(32), .CLEAR_ON_BUBBLE(1'b0)) dut_keep (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occupancy)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of at most two entries. Acceptance is decided by the
    // queue length before the edge; flush empties it after any delivery.
    always @(posedge clk or negedge rst) begin : model
        int  n;
        bit  inf, outf;
        if (!rst) begin
            mq.delete();
        end else begin
            n    = mq.size();
            inf  = in_valid && (n < 2);
            outf = (n > 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (outf) void'(mq.pop_front());
                if (inf)  mq.push_back(in_data);
            end
        end
    end

    // Compare process: outputs are registered, so check mid-cycle.
    always @(negedge clk) begin
        logic [W-1:0] ed;
        if (check_en && rst) begin
            ed = (mq.size() != 0) ? mq[0] : '0;
            chk("m_out_valid", {127'd0, out_valid}, {127'd0, mq.size() != 0});
            chk("m_out_data",  {21'd0, out_data}, {21'd0, ed});
            chk("m_occupancy", {126'd0, occupancy}, 128'(mq.size()));
            chk("m_in_ready",  {127'd0, in_ready}, {127'd0, mq.size() < 2});
        end
    end

    // Apply inputs just after an edge; return just after the next edge.
    task automatic cyc(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] r;

        // reset state
        #2;
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_in_ready",  {127'd0, in_ready}, 128'd1);
        chk("rst_occ",       {126'd0, occupancy}, 128'd0);
        chk("rst_out_data",  {21'd0, out_data}, 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        check_en = 1'b1;

        // streaming at full rate
        cyc(1, 'h11, 1, 0);
        chk("st_d0", {21'd0, out_data}, 128'h11);
        chk("st_occ0", {126'd0, occupancy}, 128'd1);
        cyc(1, 'h22, 1, 0);
        chk("st_d1", {21'd0, out_data}, 128'h22);
        chk("st_rdy1", {127'd0, in_ready}, 128'd1);
        cyc(1, 'h33, 1, 0);
        chk("st_d2", {21'd0, out_data}, 128'h33);
        chk("st_occ2", {126'd0, occupancy}, 128'd1);
        cyc(0, '0, 1, 0);
        chk("st_drain_v", {127'd0, out_valid}, 128'd0);
        chk("st_drain_d", {21'd0, out_data}, 128'd0);

        // stall into skid, then recover
        cyc(1, 'hA1, 0, 0);
        chk("sk_rdy0", {127'd0, in_ready}, 128'd1);
        cyc(1, 'hA2, 0, 0);
        chk("sk_rdy1", {127'd0, in_ready}, 128'd0);
        chk("sk_occ1", {126'd0, occupancy}, 128'd2);
        cyc(1, 'hA3, 0, 0);
        chk("sk_hold_d", {21'd0, out_data}, 128'hA1);
        chk("sk_hold_occ", {126'd0, occupancy}, 128'd2);
        cyc(1, 'hA3, 1, 0);
        chk("sk_rec_d", {21'd0, out_data}, 128'hA2);
        chk("sk_rec_rdy", {127'd0, in_ready}, 128'd1);
        cyc(1, 'hA3, 1, 0);
        chk("sk_last_d", {21'd0, out_data}, 128'hA3);
        chk("sk_last_occ", {126'd0, occupancy}, 128'd1);
        cyc(0, '0, 1, 0);
        chk("sk_empty", {126'd0, occupancy}, 128'd0);

        // flush from FULL with a pending offer
        cyc(1, 'hC1, 0, 0);
        cyc(1, 'hC2, 0, 0);
        cyc(1, 'hBEEF, 0, 1);
        chk("fl_occ", {126'd0, occupancy}, 128'd0);
        chk("fl_v", {127'd0, out_valid}, 128'd0);
        chk("fl_d", {21'd0, out_data}, 128'd0);
        // flush from ONE while both sides fire: the accepted beat is dropped
        cyc(1, 'hD1, 0, 0);
        cyc(1, 'hBEEF, 1, 1);
        chk("fl1_occ", {126'd0, occupancy}, 128'd0);
        cyc(0, '0, 1, 0);
        chk("fl1_d", {21'd0, out_data}, 128'd0);
        chk("fl1_v", {127'd0, out_valid}, 128'd0);

        // asynchronous reset in the middle of a cycle while FULL
        cyc(1, 'hE1, 0, 0);
        cyc(1, 'hE2, 0, 0);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("ar_occ", {126'd0, occupancy}, 128'd0);
        chk("ar_v", {127'd0, out_valid}, 128'd0);
        chk("ar_rdy", {127'd0, in_ready}, 128'd1);
        chk("ar_d", {21'd0, out_data}, 128'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // bubble masking, both settings
        b_in_valid = 1'b1; b_in_data = 32'hFFFF_FFFF; b_out_ready = 1'b1;
        cyc(1, 'hFFFF_FFFF, 1, 0);
        chk("bm_d", {21'd0, out_data}, 128'hFFFF_FFFF);
        chk("bk_d", {96'd0, b_out_data}, 128'hFFFF_FFFF);
        b_in_valid = 1'b0;
        cyc(0, '0, 1, 0);
        chk("bm_clear", {21'd0, out_data}, 128'd0);
        chk("bk_v", {127'd0, b_out_valid}, 128'd0);
        chk("bk_occ", {126'd0, b_occupancy}, 128'd0);
        chk("bk_keep", {96'd0, b_out_data}, 128'hFFFF_FFFF);
        chk("bk_rdy", {127'd0, b_in_ready}, 128'd1);
        b_out_ready = 1'b0;

        // random traffic with back-pressure and occasional flush
        for (int i = 0; i < 10000; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            cyc($urandom_range(0, 3) != 0, r[W-1:0], $urandom_range(0, 2) != 0,
                $urandom_range(0, 40) == 0);
        end
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        chk("end_empty", {126'd0, occupancy}, 128'd0);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
